// File: rtl/axis_rx_arb_pkg.sv
// Shared constants and types for the AXI-Stream receive arbiter/mux.
// Arbitration mode selectors, FSM state encoding and an index-width helper.
package axis_rx_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Width of a channel index; a single channel still gets a 1-bit id.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rx_rr_arbiter.sv
// Combinational grant picker: fixed priority (ch0 first) or round-robin from ptr+1.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when a grant is registered.
module axis_rx_rr_arbiter
  import axis_rx_arb_pkg::*;
#(
  parameter int  NUM_CH = 2,
  localparam int IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx
);

  int   start_ch;
  logic found;

  // Two passes emulate a wrap-around search starting at start_ch.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    start_ch = 0;
    if (mode && (int'(ptr) < NUM_CH - 1)) begin
      start_ch = int'(ptr) + 1;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (i >= start_ch)) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (i < start_ch)) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/axis_rx_arb_mux.sv
// Packet-locked N:1 AXI-Stream merge; optional per-channel packet counters (RX_ARB_MUX_PKT_CNT_EN).
// Latency: 1 cycle input to registered output; one bubble cycle between packets.
// Backpressure: granted channel sees tready = !rx_user_tvalid || rx_user_tready; others see 0.
module axis_rx_arb_mux
  import axis_rx_arb_pkg::*;
#(
  parameter int  NUM_CH   = 2,
  parameter int  DATA_W   = 64,
  parameter int  ARB_MODE = ARB_RR,
  localparam int KEEP_W   = DATA_W / 8,
  localparam int TID_W    = idx_w(NUM_CH)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_CH*DATA_W-1:0] rx_src_tdata,
  input  logic [NUM_CH*KEEP_W-1:0] rx_src_tkeep,
  input  logic [NUM_CH-1:0]        rx_src_tvalid,
  input  logic [NUM_CH-1:0]        rx_src_tlast,
  output logic [NUM_CH-1:0]        rx_src_tready,
  output logic [DATA_W-1:0]        rx_user_tdata,
  output logic [KEEP_W-1:0]        rx_user_tkeep,
  output logic                     rx_user_tvalid,
  output logic                     rx_user_tlast,
  output logic [TID_W-1:0]         rx_user_tid,
`ifdef RX_ARB_MUX_PKT_CNT_EN
  output logic [NUM_CH*32-1:0]     rx_pkt_cnt,
`endif
  input  logic                     rx_user_tready
);

  state_t              state_q, state_d;
  logic [TID_W-1:0]    last_q;
  logic [NUM_CH-1:0]   gnt_oh_q;
  logic [NUM_CH-1:0]   arb_gnt;
  logic [TID_W-1:0]    arb_idx;
  logic                any_req;
  logic                can_load;
  logic                accept;
  logic                accept_last;
  logic [DATA_W-1:0]   sel_dat;
  logic [KEEP_W-1:0]   sel_keep;
  logic                sel_last;

  assign any_req     = |rx_src_tvalid;
  assign can_load    = !rx_user_tvalid || rx_user_tready;
  assign accept      = |(rx_src_tvalid & rx_src_tready);
  assign accept_last = accept && sel_last;

  axis_rx_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req     (rx_src_tvalid),
    .ptr     (last_q),
    .mode    (ARB_MODE == ARB_RR),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_LOCKED;
      ST_LOCKED: if (accept_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_src_tready = '0;
    if ((state_q == ST_LOCKED) && can_load) begin
      rx_src_tready = gnt_oh_q;
    end
  end

  // last_q doubles as the current grant: it only moves when a new grant is issued.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_q   <= TID_W'(NUM_CH - 1);
      gnt_oh_q <= '0;
    end else if ((state_q == ST_IDLE) && any_req) begin
      last_q   <= arb_idx;
      gnt_oh_q <= arb_gnt;
    end
  end

  always_comb begin
    sel_dat  = '0;
    sel_keep = '0;
    sel_last = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_oh_q[c]) begin
        sel_dat  = rx_src_tdata[c*DATA_W +: DATA_W];
        sel_keep = rx_src_tkeep[c*KEEP_W +: KEEP_W];
        sel_last = rx_src_tlast[c];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_user_tvalid <= 1'b0;
      rx_user_tdata  <= '0;
      rx_user_tkeep  <= '0;
      rx_user_tlast  <= 1'b0;
      rx_user_tid    <= '0;
    end else if (accept) begin
      rx_user_tvalid <= 1'b1;
      rx_user_tdata  <= sel_dat;
      rx_user_tkeep  <= sel_keep;
      rx_user_tlast  <= sel_last;
      rx_user_tid    <= last_q;
    end else if (rx_user_tready) begin
      rx_user_tvalid <= 1'b0;
    end
  end

`ifdef RX_ARB_MUX_PKT_CNT_EN
  logic [31:0] pkt_cnt_q [NUM_CH];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NUM_CH; c++) pkt_cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept_last && gnt_oh_q[c]) pkt_cnt_q[c] <= pkt_cnt_q[c] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign rx_pkt_cnt[g*32 +: 32] = pkt_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_axis_rx_arb_mux.sv
// Bench for axis_rx_arb_mux: arbitration vector table, directed corner sequences,
// and a randomized run checked by a per-channel packet scoreboard.
module tb_axis_rx_arb_mux;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam logic [63:0] PAT_A5 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] PAT_11 = 64'h1111_2222_3333_4444;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [63:0] sd [NUM_CH];
  logic [7:0]  sk [NUM_CH];
  logic        sv [NUM_CH];
  logic        sl [NUM_CH];

  logic [NUM_CH*DATA_W-1:0] src_tdata;
  logic [NUM_CH*KEEP_W-1:0] src_tkeep;
  logic [NUM_CH-1:0]        src_tvalid, src_tlast;
  logic [NUM_CH-1:0]        src_tready, fp_tready;
  logic [63:0] u_tdata, fp_tdata;
  logic [7:0]  u_tkeep, fp_tkeep;
  logic        u_tvalid, u_tlast, u_tid, fp_tvalid, fp_tlast, fp_tid;
  logic        u_tready;
`ifdef RX_ARB_MUX_PKT_CNT_EN
  logic [NUM_CH*32-1:0] pkt_cnt, fp_pkt_cnt;
`endif

  assign src_tdata  = {sd[1], sd[0]};
  assign src_tkeep  = {sk[1], sk[0]};
  assign src_tvalid = {sv[1], sv[0]};
  assign src_tlast  = {sl[1], sl[0]};

  axis_rx_arb_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ARB_MODE(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .rx_src_tdata(src_tdata), .rx_src_tkeep(src_tkeep), .rx_src_tvalid(src_tvalid),
    .rx_src_tlast(src_tlast), .rx_src_tready(src_tready),
    .rx_user_tdata(u_tdata), .rx_user_tkeep(u_tkeep), .rx_user_tvalid(u_tvalid),
    .rx_user_tlast(u_tlast), .rx_user_tid(u_tid),
`ifdef RX_ARB_MUX_PKT_CNT_EN
    .rx_pkt_cnt(pkt_cnt),
`endif
    .rx_user_tready(u_tready)
  );

  axis_rx_arb_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ARB_MODE(0)) dut_fp (
    .aclk(aclk), .aresetn(aresetn),
    .rx_src_tdata(src_tdata), .rx_src_tkeep(src_tkeep), .rx_src_tvalid(src_tvalid),
    .rx_src_tlast(src_tlast), .rx_src_tready(fp_tready),
    .rx_user_tdata(fp_tdata), .rx_user_tkeep(fp_tkeep), .rx_user_tvalid(fp_tvalid),
    .rx_user_tlast(fp_tlast), .rx_user_tid(fp_tid),
`ifdef RX_ARB_MUX_PKT_CNT_EN
    .rx_pkt_cnt(fp_pkt_cnt),
`endif
    .rx_user_tready(u_tready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] dat;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int    cyc;
    int    tid;
    beat_t b;
  } log_t;

  beat_t src_q [NUM_CH][$];
  beat_t exp_q [NUM_CH][$];
  log_t  olog[$];
  int    cyc = 0;
  int    vld_pct = 100;
  int    rdy_pct = 100;
  bit    off [NUM_CH];
  bit    in_pkt;
  int    cur_tid;
  bit    pv, pr;
  logic [63:0] p_dat;
  logic [9:0]  p_ctl;

  task automatic clear_tb();
    for (int c = 0; c < NUM_CH; c++) begin
      src_q[c].delete();
      exp_q[c].delete();
      off[c] = 1'b0;
      sv[c] = 1'b0; sl[c] = 1'b0; sd[c] = '0; sk[c] = '0;
    end
    olog.delete();
    in_pkt = 1'b0;
    pv = 1'b0;
    pr = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_tb();
    u_tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic push_pkt(input int c, input int len, input logic [63:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.dat  = base + 64'(i);
      b.keep = 8'($urandom_range(1, 255));
      b.last = (i == len - 1);
      src_q[c].push_back(b);
      exp_q[c].push_back(b);
    end
  endtask

  task automatic drive_srcs();
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_q[c].size() > 0 && !off[c] && ($urandom_range(0, 99) < vld_pct)) begin
        sv[c] = 1'b1;
        sd[c] = src_q[c][0].dat;
        sk[c] = src_q[c][0].keep;
        sl[c] = src_q[c][0].last;
      end else begin
        sv[c] = 1'b0; sd[c] = '0; sk[c] = '0; sl[c] = 1'b0;
      end
    end
  endtask

  // One clock of driver + scoreboard: sample at negedge, advance sources after the edge.
  task automatic run_cycles(input int n);
    logic [NUM_CH-1:0] acc;
    beat_t e;
    int t;
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      acc = src_tvalid & src_tready;
      check("tready_onehot0", 64'($countones(src_tready) <= 1), 64'd1);
      if (pv && !pr) begin
        check("hold_data", u_tdata, p_dat);
        check("hold_ctl", {54'd0, u_tkeep, u_tlast, u_tid}, {54'd0, p_ctl});
        check("hold_valid", u_tvalid, 1'b1);
      end
      if (u_tvalid && u_tready) begin
        t = int'(u_tid);
        if (in_pkt) check("no_interleave", t, cur_tid);
        if (exp_q[t].size() == 0) begin
          check("unexpected_beat_tid", t, 64'hFFFF);
        end else begin
          e = exp_q[t].pop_front();
          check("sb_data", u_tdata, e.dat);
          check("sb_keep_last", {u_tkeep, u_tlast}, {e.keep, e.last});
        end
        in_pkt  = !u_tlast;
        cur_tid = t;
        olog.push_back('{cyc, t, '{u_tdata, u_tkeep, u_tlast}});
      end
      pv = u_tvalid; pr = u_tready;
      p_dat = u_tdata; p_ctl = {u_tkeep, u_tlast, u_tid};
      @(posedge aclk);
      cyc++;
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (((acc >> c) & 2'b01) != 0) void'(src_q[c].pop_front());
      end
      drive_srcs();
      u_tready = ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  function automatic logic [63:0] vec_dat(input int v, input int c);
    return 64'hD000_0000_0000_0000 | (64'(v) << 8) | 64'(c);
  endfunction

  typedef struct {
    logic [1:0] mask;
    int         rr_tid;
    int         fp_tid;
  } vec_t;

  vec_t vec [8];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a5_cnt;
    int left;
    int guard;

    vec[0] = '{2'b11, 0, 0};
    vec[1] = '{2'b11, 1, 0};
    vec[2] = '{2'b01, 0, 0};
    vec[3] = '{2'b01, 0, 0};
    vec[4] = '{2'b10, 1, 1};
    vec[5] = '{2'b10, 1, 1};
    vec[6] = '{2'b11, 0, 0};
    vec[7] = '{2'b11, 1, 0};

    // Reset values, checked while reset is still asserted.
    aresetn = 1'b0;
    clear_tb();
    u_tready = 1'b0;
    #12;
    check("rst_tvalid", u_tvalid, 1'b0);
    check("rst_tdata", u_tdata, 64'd0);
    check("rst_ctl", {u_tkeep, u_tlast, u_tid}, 10'd0);
    check("rst_tready", src_tready, 2'b00);
    do_reset();

    // Single-beat packets: grant order after reset for both arbitration modes.
    for (int v = 0; v < 8; v++) begin
      u_tready = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        sv[c] = vec[v].mask[c];
        sd[c] = vec_dat(v, c);
        sk[c] = 8'hFF;
        sl[c] = 1'b1;
      end
      @(negedge aclk);
      check("vec_idle_tready", src_tready, 2'b00);
      @(posedge aclk); #1;
      @(negedge aclk);
      check("vec_rr_tready", src_tready, 2'b01 << vec[v].rr_tid);
      check("vec_fp_tready", fp_tready, 2'b01 << vec[v].fp_tid);
      @(posedge aclk); #1;
      for (int c = 0; c < NUM_CH; c++) sv[c] = 1'b0;
      @(negedge aclk);
      check("vec_rr_out", {u_tvalid, u_tlast, u_tid}, {2'b11, 1'(vec[v].rr_tid)});
      check("vec_rr_data", u_tdata, vec_dat(v, vec[v].rr_tid));
      check("vec_fp_out", {fp_tvalid, fp_tid}, {1'b1, 1'(vec[v].fp_tid)});
      check("vec_fp_data", fp_tdata, vec_dat(v, vec[v].fp_tid));
      @(posedge aclk); #1;
    end

    // Two 3-beat packets requested together: ch0 pkt, one bubble, ch1 pkt.
    do_reset();
    vld_pct = 100; rdy_pct = 100;
    push_pkt(0, 3, 64'h0A00);
    push_pkt(1, 3, 64'h1B00);
    drive_srcs();
    u_tready = 1'b1;
    run_cycles(14);
    check("rr3_count", olog.size(), 6);
    if (olog.size() == 6) begin
      for (int i = 0; i < 6; i++) check("rr3_tid", olog[i].tid, (i < 3) ? 0 : 1);
      for (int i = 1; i < 6; i++) check("rr3_gap", olog[i].cyc - olog[i-1].cyc, (i == 3) ? 2 : 1);
    end

    // Fixed priority with both channels streaming: ch1 never served.
    do_reset();
    sv[0] = 1'b1; sv[1] = 1'b1; sl[0] = 1'b0; sl[1] = 1'b0;
    sd[0] = 64'h34; sd[1] = 64'h35; sk[0] = 8'hFF; sk[1] = 8'hFF;
    u_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("fp_tready1_low", (fp_tready >> 1) & 2'b01, 2'b00);
      if (fp_tvalid) check("fp_tid0", fp_tid, 1'b0);
      @(posedge aclk); #1;
    end
    @(negedge aclk);
    check("fp_streaming", {fp_tvalid, fp_tready}, 3'b101);

    // Downstream stall mid-packet: output frozen, one acceptance after release.
    do_reset();
    sv[0] = 1'b1; sd[0] = PAT_A5; sk[0] = 8'hFF; sl[0] = 1'b0;
    u_tready = 1'b0;
    a5_cnt = 0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    sd[0] = PAT_11;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("stall_data", u_tdata, PAT_A5);
      check("stall_vld_rdy", {u_tvalid, src_tready}, 3'b100);
      @(posedge aclk); #1;
    end
    u_tready = 1'b1;
    @(negedge aclk);
    check("release_tready", src_tready, 2'b01);
    if (u_tvalid && u_tready && u_tdata == PAT_A5) a5_cnt++;
    @(posedge aclk); #1;
    u_tready = 1'b0; sv[0] = 1'b0;
    @(negedge aclk);
    check("after_release_data", {63'd0, u_tvalid}, 64'd1);
    check("after_release_next", u_tdata, PAT_11);
    u_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      if (u_tvalid && u_tready && u_tdata == PAT_A5) a5_cnt++;
      @(posedge aclk); #1;
    end
    @(negedge aclk);
    check("a5_accept_once", a5_cnt, 1);
    check("drained_vld", u_tvalid, 1'b0);

    // ch1 valid gaps mid-packet while ch0 waits: lock stays on ch1.
    do_reset();
    vld_pct = 100; rdy_pct = 100;
    push_pkt(1, 4, 64'h3600);
    drive_srcs();
    u_tready = 1'b1;
    run_cycles(3);
    push_pkt(0, 6, 64'h3700);
    off[1] = 1'b1;
    drive_srcs();
    run_cycles(2);
    off[1] = 1'b0;
    drive_srcs();
    run_cycles(20);
    check("lock_count", olog.size(), 10);
    if (olog.size() == 10) begin
      for (int i = 0; i < 10; i++) check("lock_tid", olog[i].tid, (i < 4) ? 1 : 0);
      check("lock_last", olog[3].b.last, 1'b1);
    end

    // Reset pulse mid-packet: outputs clear immediately, ch0 first afterwards.
    do_reset();
    vld_pct = 100; rdy_pct = 100;
    push_pkt(0, 8, 64'h4700);
    drive_srcs();
    u_tready = 1'b1;
    run_cycles(4);
    #2;
    check("pre_reset_vld", u_tvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_vld", u_tvalid, 1'b0);
    check("mid_rst_data", u_tdata, 64'd0);
    check("mid_rst_ctl", {u_tkeep, u_tlast, u_tid}, 10'd0);
    check("mid_rst_tready", src_tready, 2'b00);
    clear_tb();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    push_pkt(0, 2, 64'h5000);
    push_pkt(1, 2, 64'h5100);
    drive_srcs();
    run_cycles(12);
    check("post_rst_count", olog.size(), 4);
    if (olog.size() > 0) check("post_rst_first_tid", olog[0].tid, 0);

`ifdef RX_ARB_MUX_PKT_CNT_EN
    do_reset();
    check("cnt_reset", pkt_cnt, 64'd0);
    for (int p = 0; p < 5; p++) push_pkt(1, 1 + (p % 3), 64'h6000 + 64'(p << 4));
    drive_srcs();
    u_tready = 1'b1;
    run_cycles(40);
    check("cnt_ch1", pkt_cnt[63:32], 64'd5);
    check("cnt_ch0", pkt_cnt[31:0], 64'd0);
`endif

    // Randomized traffic with valid gaps and downstream stalls.
    do_reset();
    vld_pct = 70; rdy_pct = 70;
    for (int p = 0; p < 60; p++) begin
      int c;
      c = $urandom_range(0, NUM_CH - 1);
      push_pkt(c, $urandom_range(1, 6), (64'(c) << 32) | (64'(p) << 16));
    end
    drive_srcs();
    guard = 0;
    left = 1;
    while (left > 0 && guard < 6000) begin
      run_cycles(1);
      guard++;
      left = 0;
      for (int c = 0; c < NUM_CH; c++) left += exp_q[c].size();
    end
    check("random_drain_left", left, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_rx_arb_mux.md
AXIS_RX_ARB_MUX -- requirements
Module: axis_rx_arb_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of source channels, legal range 1..8.
REQ-002 SHALL have parameter DATA_W, default 64: tdata width; KEEP_W = DATA_W/8.
REQ-003 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority (channel 0 highest), 1 = round-robin.
REQ-004 SHALL have port aclk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port rx_src_tdata, input, NUM_CH*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
REQ-007 SHALL have port rx_src_tkeep, input, NUM_CH*KEEP_W: per-channel byte enables, same packing as tdata.
REQ-008 SHALL have port rx_src_tvalid, input, NUM_CH: per-channel valid.
REQ-009 SHALL have port rx_src_tlast, input, NUM_CH: per-channel end of packet.
REQ-010 SHALL have port rx_src_tready, output, NUM_CH: per-channel ready.
REQ-011 SHALL have ports rx_user_tdata (output, DATA_W), rx_user_tkeep (output, KEEP_W), rx_user_tvalid (output, 1) and rx_user_tlast (output, 1): the registered merged stream.
REQ-012 SHALL have port rx_user_tready, input, 1: downstream ready.
REQ-013 SHALL have port rx_user_tid, output, clog2(NUM_CH) (min 1): source channel of the current beat.

Function
REQ-014 SHALL implement states IDLE and LOCKED.
REQ-015 IDLE: if any rx_src_tvalid is set, SHALL register a grant per ARB_MODE and move to LOCKED next cycle; no beat is accepted in IDLE.
REQ-016 Round-robin SHALL search from (last_grant+1) mod NUM_CH upward with wrap-around; last_grant SHALL update only when a grant is issued.
REQ-017 LOCKED: rx_src_tready[g] SHALL be (!rx_user_tvalid || rx_user_tready); all other rx_src_tready bits SHALL be 0.
REQ-018 A beat SHALL transfer when rx_src_tvalid[g] && rx_src_tready[g]; the output register SHALL load data, keep, last and tid in the same edge; latency 1 cycle.
REQ-019 Output register SHALL hold all rx_user_* values stable while rx_user_tvalid && !rx_user_tready.
REQ-020 rx_user_tvalid SHALL clear when the downstream accepts a beat and no new beat loads in that cycle.
REQ-021 Acceptance of a beat with tlast=1 SHALL return the FSM to IDLE; the next grant costs one bubble cycle.
REQ-022 Deassertion of rx_src_tvalid[g] mid-packet SHALL NOT release the lock; the grant is held until tlast.
REQ-023 A single-beat packet (tlast on the first beat) SHALL take LOCKED for exactly one accepted beat.
REQ-024 Simultaneous requests SHALL be resolved solely by REQ-015/016; a channel whose request is ungranted SHALL see tready=0.

Reset
REQ-025 On aresetn=0, the block SHALL immediately enter IDLE and clear rx_user_tvalid, rx_user_tlast, rx_user_tdata, rx_user_tkeep, rx_user_tid and rx_src_tready to 0.
REQ-026 On aresetn=0, last_grant SHALL be set to NUM_CH-1, so channel 0 is checked first.
REQ-027 Reset mid-packet SHALL discard the partial packet with no further beats emitted; recovery is the system's responsibility.

Configuration
REQ-028 With RX_ARB_MUX_PKT_CNT_EN defined, the block SHALL add output rx_pkt_cnt (NUM_CH*32) of per-channel counters.
REQ-029 Each counter SHALL increment on every accepted tlast beat, wrap from 0xFFFFFFFF to 0, and reset to 0.
REQ-030 Without RX_ARB_MUX_PKT_CNT_EN, the rx_pkt_cnt port and the counters SHALL be absent.

Structure
REQ-031 Package axis_rx_arb_pkg SHALL hold the ARB_FIXED/ARB_RR constants and the state type.
REQ-032 Grant computation SHALL be a combinational sub-module, axis_rx_rr_arbiter (inputs: request vector, pointer, mode; output: one-hot grant plus index).

Verification
REQ-033 NUM_CH=2, ARB_MODE=1, both channels valid with 3-beat packets: output SHALL be ch0 pkt, 1 bubble, ch1 pkt, with rx_user_tid of 0,0,0 then 1,1,1.
REQ-034 ARB_MODE=0, ch0 and ch1 continuously valid: only ch0 SHALL be granted and rx_src_tready[1] SHALL stay 0.
REQ-035 rx_user_tready held low for 4 cycles mid-packet with data 0xA5A5A5A5A5A5A5A5: output SHALL be stable and exactly one beat SHALL be accepted after release.
REQ-036 tvalid dropped for 2 cycles mid-packet on ch1 while ch0 is valid: the grant SHALL stay on ch1 until its tlast.
REQ-037 aresetn pulsed low mid-packet: outputs SHALL be 0 within the same cycle, and after release the first grant SHALL go to ch0.
REQ-038 With RX_ARB_MUX_PKT_CNT_EN defined, 5 packets on ch1: rx_pkt_cnt for ch1 SHALL be 5 and for ch0 SHALL be 0.
